// File: rtl/display_spi_arbiter_pkg.sv
// Shared types and constants for the display SPI arbiter: default frame
// geometry, FSM state encoding and the idle levels of the SPI pins.
package display_spi_arbiter_pkg;

    localparam int FRAME_BITS_DEF = 16;
    localparam int CLK_DIV_DEF    = 2;
    localparam int SS_GAP_DEF     = 2;

    // Idle (deasserted) levels of the SPI pins.
    localparam logic SS_IDLE   = 1'b1;
    localparam logic SCLK_IDLE = 1'b1;
    localparam logic MOSI_IDLE = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    // True in the states where slave select is asserted.
    function automatic logic in_frame(input state_t s);
        return (s == S_SETUP) || (s == S_SHIFT) || (s == S_HOLD);
    endfunction

endpackage

// File: rtl/display_spi_arbiter_shifter.sv
// SPI bit engine: divide counter, bit counter, shift register and the
// registered sclk/mosi pins. The parent FSM tells it which phase it is in;
// it reports half-period ticks and a done strobe on the last bit.
module display_spi_arbiter_shifter
    import display_spi_arbiter_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int CLK_DIV    = CLK_DIV_DEF
) (
    input  logic                  clock_5meg_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [FRAME_BITS-1:0] frame_i,
    input  state_t                state_i,
    output logic                  tick_o,
    output logic                  done_o,
    output logic                  spi_sclk_o,
    output logic                  spi_mosi_o
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    logic [DIV_W-1:0]      div_q, div_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  half_q, half_d;   // 0: sclk-low half, 1: sclk-high half
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic                  sclk_q, sclk_d;

    // Half-period tick and end-of-last-bit strobe for the parent FSM.
    always_comb begin
        tick_o = in_frame(state_i) && (div_q == DIV_LAST);
        done_o = (state_i == S_SHIFT) && tick_o && half_q && (bit_q == BIT_LAST);
    end

    // Next-state of the bit engine: sclk falls/rises on ticks, mosi moves only on falls.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        div_d   = div_q;
        bit_d   = bit_q;
        half_d  = half_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        if (load_i) begin
            div_d   = '0;
            bit_d   = '0;
            half_d  = 1'b0;
            shreg_d = frame_i;
            sclk_d  = SCLK_IDLE;
        end else if (in_frame(state_i)) begin
            div_d = tick_o ? '0 : div_q + 1'b1;
            if (tick_o) begin
                case (state_i)
                    S_SETUP: sclk_d = 1'b0;
                    S_SHIFT: begin
                        if (!half_q) begin
                            sclk_d = 1'b1;
                            half_d = 1'b1;
                        end else begin
                            half_d = 1'b0;
                            if (bit_q != BIT_LAST) begin
                                bit_d   = bit_q + 1'b1;
                                sclk_d  = 1'b0;
                                shreg_d = {shreg_q[FRAME_BITS-2:0], MOSI_IDLE};
                            end
                        end
                    end
                    S_HOLD:  shreg_d = {FRAME_BITS{MOSI_IDLE}};
                    default: ;
                endcase
            end
        end
    end

    // Bit engine registers with synchronous reset.
    always_ff @(posedge clock_5meg_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            div_q   <= '0;
            bit_q   <= '0;
            half_q  <= 1'b0;
            // NOTE: the shift register is reset because its MSB is the mosi pin itself.
            shreg_q <= {FRAME_BITS{MOSI_IDLE}};
            sclk_q  <= SCLK_IDLE;
        end else begin
            div_q   <= div_d;
            bit_q   <= bit_d;
            half_q  <= half_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
        end
    end

    assign spi_sclk_o = sclk_q;
    assign spi_mosi_o = shreg_q[FRAME_BITS-1];

endmodule

// File: rtl/display_spi_arbiter.sv
// Two-requester round-robin arbiter in front of an SPI master. A granted
// frame is latched and sent atomically under slave select, followed by a
// minimum slave-select-high gap before the next grant.
module display_spi_arbiter
    import display_spi_arbiter_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int CLK_DIV    = CLK_DIV_DEF,
    parameter int SS_GAP     = SS_GAP_DEF
) (
    input  logic                  clock_5meg_i,
    input  logic                  rst_i,
    input  logic                  req0_i,
    input  logic [FRAME_BITS-1:0] frame0_i,
    output logic                  ack0_o,
    input  logic                  req1_i,
    input  logic [FRAME_BITS-1:0] frame1_i,
    output logic                  ack1_o,
    output logic                  busy_o,
    output logic                  spi_sclk_o,
    output logic                  spi_ss_o,
    output logic                  spi_mosi_o
);

    localparam int GAP_W = $clog2(SS_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SS_GAP - 1);

    state_t           state_q, state_d;
    logic             owner_q, owner_d;    // requester currently being served
    logic             last_q, last_d;      // requester served most recently
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             ss_q, ss_d;
    logic             busy_q, busy_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;

    logic                  grant_sel;
    logic                  load;
    logic                  tick;
    logic                  done;
    logic [FRAME_BITS-1:0] load_frame;

    // Round-robin choice: on contention, the requester not served last wins.
    assign grant_sel  = (req0_i && req1_i) ? ~last_q : req1_i;
    assign load_frame = grant_sel ? frame1_i : frame0_i;

    // State register and arbiter bookkeeping.
    always_ff @(posedge clock_5meg_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;  // requester 1 "served last" gives requester 0 priority
            gap_q   <= '0;
            ss_q    <= SS_IDLE;
            busy_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            ss_q    <= ss_d;
            busy_q  <= busy_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    // Next-state logic: grant, frame phases, then the slave-select gap.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        gap_d   = gap_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0_i || req1_i) begin
                    state_d = S_SETUP;
                    owner_d = grant_sel;
                    load    = 1'b1;
                end
            end
            S_SETUP: if (tick) state_d = S_SHIFT;
            S_SHIFT: if (done) state_d = S_HOLD;
            S_HOLD: begin
                if (tick) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                    last_d  = owner_q;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = S_IDLE;
                else                   gap_d   = gap_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so every pin leaves a flop.
    always_comb begin
        ss_d   = in_frame(state_d) ? ~SS_IDLE : SS_IDLE;
        busy_d = (state_d != S_IDLE);
        ack0_d = (state_q == S_HOLD) && (state_d == S_GAP) && !owner_q;
        ack1_d = (state_q == S_HOLD) && (state_d == S_GAP) &&  owner_q;
    end

    display_spi_arbiter_shifter #(
        .FRAME_BITS (FRAME_BITS),
        .CLK_DIV    (CLK_DIV)
    ) u_shifter (
        .clock_5meg_i (clock_5meg_i),
        .rst_i        (rst_i),
        .load_i       (load),
        .frame_i      (load_frame),
        .state_i      (state_q),
        .tick_o       (tick),
        .done_o       (done),
        .spi_sclk_o   (spi_sclk_o),
        .spi_mosi_o   (spi_mosi_o)
    );

    assign spi_ss_o = ss_q;
    assign busy_o   = busy_q;
    assign ack0_o   = ack0_q;
    assign ack1_o   = ack1_q;

endmodule

// File: tb/tb_display_spi_arbiter.sv
// Directed bench for display_spi_arbiter: one instance with default
// parameters and one with CLK_DIV=1, observed by a passive SPI slave monitor.
module tb_display_spi_arbiter;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        rst_a, req0_a, req1_a;
    logic [15:0] frame0_a, frame1_a;
    logic        ack0_a, ack1_a, busy_a, sclk_a, ss_a, mosi_a;

    logic        rst_b, req0_b, req1_b;
    logic [15:0] frame0_b, frame1_b;
    logic        ack0_b, ack1_b, busy_b, sclk_b, ss_b, mosi_b;

    display_spi_arbiter dut_a (
        .clock_5meg_i (clk),      .rst_i      (rst_a),
        .req0_i       (req0_a),   .frame0_i   (frame0_a), .ack0_o (ack0_a),
        .req1_i       (req1_a),   .frame1_i   (frame1_a), .ack1_o (ack1_a),
        .busy_o       (busy_a),   .spi_sclk_o (sclk_a),
        .spi_ss_o     (ss_a),     .spi_mosi_o (mosi_a)
    );

    display_spi_arbiter #(.CLK_DIV(1)) dut_b (
        .clock_5meg_i (clk),      .rst_i      (rst_b),
        .req0_i       (req0_b),   .frame0_i   (frame0_b), .ack0_o (ack0_b),
        .req1_i       (req1_b),   .frame1_i   (frame1_b), .ack1_o (ack1_b),
        .busy_o       (busy_b),   .spi_sclk_o (sclk_b),
        .spi_ss_o     (ss_b),     .spi_mosi_o (mosi_b)
    );

    logic ss_s [2], sclk_s [2], mosi_s [2], busy_s [2];
    logic ack_s [2][2];
    assign ss_s[0] = ss_a;     assign ss_s[1] = ss_b;
    assign sclk_s[0] = sclk_a; assign sclk_s[1] = sclk_b;
    assign mosi_s[0] = mosi_a; assign mosi_s[1] = mosi_b;
    assign busy_s[0] = busy_a; assign busy_s[1] = busy_b;
    assign ack_s[0][0] = ack0_a; assign ack_s[0][1] = ack1_a;
    assign ack_s[1][0] = ack0_b; assign ack_s[1][1] = ack1_b;

    // Monitor state (written only by the monitor processes).
    int          cyc_n = 0;
    logic        prev_ss [2], prev_sclk [2], prev_mosi [2], prev_busy [2];
    logic [15:0] cur_bits [2];
    int          cur_len [2], cur_rises [2], cur_high [2], cur_gap [2];
    int          last_rise [2], pmin [2], pmax [2];
    int          blow [2], last_blow [2];
    int          viol [2], ack_bad [2], noack [2];
    int          ack_hi [2][2];
    int          fr_cnt [2];
    logic [15:0] fr_bits [2][32];
    int          fr_len [2][32], fr_rises [2][32], fr_gap [2][32];
    int          fr_pmin [2][32], fr_pmax [2][32];

    int checks = 0;
    int errors = 0;

    initial begin
        for (int i = 0; i < 2; i++) begin
            prev_ss[i] = 1'b1; prev_sclk[i] = 1'b1; prev_mosi[i] = 1'b1; prev_busy[i] = 1'b0;
        end
    end

    always @(negedge clk) cyc_n <= cyc_n + 1;

    // Passive slave model: captures bits on sclk rising edges while ss is low,
    // logs each frame on ss rising, and counts protocol violations.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        always @(negedge clk) begin
            prev_ss[g]   <= ss_s[g];
            prev_sclk[g] <= sclk_s[g];
            prev_mosi[g] <= mosi_s[g];
            prev_busy[g] <= busy_s[g];
            viol[g] <= viol[g]
                + ((ss_s[g] === 1'b0 && busy_s[g] !== 1'b1) ? 1 : 0)
                + ((ss_s[g] === 1'b0 && prev_ss[g] === 1'b0 && sclk_s[g] === 1'b1 &&
                    prev_sclk[g] === 1'b1 && mosi_s[g] !== prev_mosi[g]) ? 1 : 0)
                + ((ss_s[g] !== 1'b0 && (sclk_s[g] !== 1'b1 || mosi_s[g] !== 1'b1)) ? 1 : 0);
            ack_hi[g][0] <= ack_hi[g][0] + ((ack_s[g][0] === 1'b1) ? 1 : 0);
            ack_hi[g][1] <= ack_hi[g][1] + ((ack_s[g][1] === 1'b1) ? 1 : 0);
            ack_bad[g] <= ack_bad[g] + (((ack_s[g][0] === 1'b1 || ack_s[g][1] === 1'b1) &&
                          !(ss_s[g] === 1'b1 && prev_ss[g] === 1'b0)) ? 1 : 0);
            if (ss_s[g] === 1'b0) begin
                cur_high[g] <= 0;
                if (prev_ss[g] !== 1'b0) begin
                    cur_len[g]   <= 1;
                    cur_bits[g]  <= '0;
                    cur_rises[g] <= 0;
                    pmin[g]      <= 1000;
                    pmax[g]      <= 0;
                    cur_gap[g]   <= cur_high[g];
                end else begin
                    cur_len[g] <= cur_len[g] + 1;
                    if (sclk_s[g] === 1'b1 && prev_sclk[g] === 1'b0) begin
                        cur_bits[g]  <= {cur_bits[g][14:0], mosi_s[g]};
                        cur_rises[g] <= cur_rises[g] + 1;
                        last_rise[g] <= cyc_n;
                        if (cur_rises[g] > 0) begin
                            if (cyc_n - last_rise[g] < pmin[g]) pmin[g] <= cyc_n - last_rise[g];
                            if (cyc_n - last_rise[g] > pmax[g]) pmax[g] <= cyc_n - last_rise[g];
                        end
                    end
                end
            end else begin
                cur_high[g] <= cur_high[g] + 1;
                if (prev_ss[g] === 1'b0) begin
                    if (fr_cnt[g] < 32) begin
                        fr_bits[g][fr_cnt[g]]  <= cur_bits[g];
                        fr_len[g][fr_cnt[g]]   <= cur_len[g];
                        fr_rises[g][fr_cnt[g]] <= cur_rises[g];
                        fr_gap[g][fr_cnt[g]]   <= cur_gap[g];
                        fr_pmin[g][fr_cnt[g]]  <= pmin[g];
                        fr_pmax[g][fr_cnt[g]]  <= pmax[g];
                    end
                    fr_cnt[g] <= fr_cnt[g] + 1;
                    noack[g]  <= noack[g] + ((ack_s[g][0] === 1'b1 || ack_s[g][1] === 1'b1) ? 0 : 1);
                end
            end
            if (busy_s[g] === 1'b1) begin
                if (prev_busy[g] !== 1'b1) last_blow[g] <= blow[g];
                blow[g] <= 0;
            end else begin
                blow[g] <= blow[g] + 1;
            end
        end
    end

    // One cycle; stimulus and sampling happen 1 time unit after the falling edge.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int d, input int r, input logic v, input logic [15:0] f);
        if (d == 0) begin
            if (r == 0) begin req0_a = v; frame0_a = f; end
            else        begin req1_a = v; frame1_a = f; end
        end else begin
            if (r == 0) begin req0_b = v; frame0_b = f; end
            else        begin req1_b = v; frame1_b = f; end
        end
    endtask

    // Request one frame, drop the request in the ack cycle, then idle a few cycles.
    task automatic run_frame(input int d, input int r, input logic [15:0] f, input string name);
        int n = 0;
        set_req(d, r, 1'b1, f);
        while (ack_s[d][r] !== 1'b1 && n < 400) begin
            cyc();
            n++;
        end
        checks++;
        if (ack_s[d][r] !== 1'b1) begin
            errors++;
            $display("FAIL %s_ack_timeout: ack=%b after %0d cycles, expected 1", name, ack_s[d][r], n);
        end
        set_req(d, r, 1'b0, f);
        repeat (4) cyc();
    endtask

    task automatic test_reset();
        int v0;
        rst_a = 1'b1; rst_b = 1'b1;
        req0_a = 1'b0; req1_a = 1'b0; frame0_a = '0; frame1_a = '0;
        req0_b = 1'b0; req1_b = 1'b0; frame0_b = '0; frame1_b = '0;
        repeat (3) cyc();
        checks++; if (ss_a !== 1'b1)   begin errors++; $display("FAIL reset_ss: got %b expected 1", ss_a); end
        checks++; if (sclk_a !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b expected 1", sclk_a); end
        checks++; if (mosi_a !== 1'b1) begin errors++; $display("FAIL reset_mosi: got %b expected 1", mosi_a); end
        checks++; if (ack0_a !== 1'b0) begin errors++; $display("FAIL reset_ack0: got %b expected 0", ack0_a); end
        checks++; if (ack1_a !== 1'b0) begin errors++; $display("FAIL reset_ack1: got %b expected 0", ack1_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        checks++; if (ss_b !== 1'b1)   begin errors++; $display("FAIL reset_ss_b: got %b expected 1", ss_b); end
        rst_a = 1'b0; rst_b = 1'b0;
        v0 = viol[0];
        repeat (10) cyc();
        checks++; if (viol[0] !== v0) begin errors++; $display("FAIL idle_quiet: violations %0d expected %0d", viol[0], v0); end
        checks++; if (fr_cnt[0] !== 0) begin errors++; $display("FAIL idle_frames: got %0d expected 0", fr_cnt[0]); end
    endtask

    task automatic test_single_frame();
        int k = fr_cnt[0], a0 = ack_hi[0][0], a1 = ack_hi[0][1], v0 = viol[0];
        run_frame(0, 0, 16'h12AA, "single");
        checks++; if (fr_cnt[0] !== k + 1)         begin errors++; $display("FAIL single_count: got %0d expected %0d", fr_cnt[0], k + 1); end
        checks++; if (fr_bits[0][k] !== 16'h12AA)  begin errors++; $display("FAIL single_bits: got %h expected 12aa", fr_bits[0][k]); end
        checks++; if (fr_rises[0][k] !== 16)       begin errors++; $display("FAIL single_rises: got %0d expected 16", fr_rises[0][k]); end
        checks++; if (fr_len[0][k] !== 68)         begin errors++; $display("FAIL single_ss_low: got %0d expected 68", fr_len[0][k]); end
        checks++; if (fr_pmin[0][k] !== 4 || fr_pmax[0][k] !== 4)
                  begin errors++; $display("FAIL single_period: got %0d..%0d expected 4", fr_pmin[0][k], fr_pmax[0][k]); end
        checks++; if (ack_hi[0][0] !== a0 + 1)     begin errors++; $display("FAIL single_ack0: got %0d expected %0d", ack_hi[0][0], a0 + 1); end
        checks++; if (ack_hi[0][1] !== a1)         begin errors++; $display("FAIL single_ack1: got %0d expected %0d", ack_hi[0][1], a1); end
        checks++; if (viol[0] !== v0)              begin errors++; $display("FAIL single_protocol: violations %0d expected %0d", viol[0], v0); end
        checks++; if (ack_bad[0] !== 0)            begin errors++; $display("FAIL single_ack_align: got %0d expected 0", ack_bad[0]); end
    endtask

    // Both requesters together; drop each request in its own ack cycle.
    task automatic both_requests(input logic [15:0] f0, input logic [15:0] f1, input string name);
        int n = 0;
        req0_a = 1'b1; frame0_a = f0;
        req1_a = 1'b1; frame1_a = f1;
        while ((req0_a || req1_a) && n < 800) begin
            cyc();
            n++;
            if (ack0_a === 1'b1) req0_a = 1'b0;
            if (ack1_a === 1'b1) req1_a = 1'b0;
        end
        checks++;
        if (req0_a || req1_a) begin
            errors++;
            $display("FAIL %s_timeout: req0=%b req1=%b still pending, expected both served", name, req0_a, req1_a);
        end
        req0_a = 1'b0; req1_a = 1'b0;
        repeat (4) cyc();
    endtask

    task automatic test_round_robin();
        int k, a0, a1;
        rst_a = 1'b1; repeat (2) cyc(); rst_a = 1'b0; cyc();
        k = fr_cnt[0]; a0 = ack_hi[0][0]; a1 = ack_hi[0][1];
        both_requests(16'h1111, 16'h2222, "rr1");
        checks++; if (fr_bits[0][k] !== 16'h1111)     begin errors++; $display("FAIL rr_first: got %h expected 1111", fr_bits[0][k]); end
        checks++; if (fr_bits[0][k + 1] !== 16'h2222) begin errors++; $display("FAIL rr_second: got %h expected 2222", fr_bits[0][k + 1]); end
        checks++; if (fr_len[0][k + 1] !== 68)        begin errors++; $display("FAIL rr_ss_low: got %0d expected 68", fr_len[0][k + 1]); end
        checks++; if (ack_hi[0][0] !== a0 + 1 || ack_hi[0][1] !== a1 + 1)
                  begin errors++; $display("FAIL rr_acks: got %0d/%0d expected %0d/%0d", ack_hi[0][0], ack_hi[0][1], a0 + 1, a1 + 1); end
        k = fr_cnt[0];
        both_requests(16'h3333, 16'h4444, "rr2");
        checks++; if (fr_bits[0][k] !== 16'h3333)     begin errors++; $display("FAIL rr_again_first: got %h expected 3333", fr_bits[0][k]); end
        checks++; if (fr_bits[0][k + 1] !== 16'h4444) begin errors++; $display("FAIL rr_again_second: got %h expected 4444", fr_bits[0][k + 1]); end
    endtask

    task automatic test_back_to_back();
        int k = fr_cnt[0], a1 = ack_hi[0][1], n = 0;
        req1_a = 1'b1; frame1_a = 16'h5A5A;
        repeat (10) cyc();
        frame1_a = 16'hFFFF;  // after the grant: must not reach the wire
        while (ack1_a !== 1'b1 && n < 400) begin cyc(); n++; end
        frame1_a = 16'hC3C3;  // req1 stays high: a new request
        cyc();
        n = 0;
        while (ack1_a !== 1'b1 && n < 400) begin cyc(); n++; end
        checks++; if (ack1_a !== 1'b1) begin errors++; $display("FAIL b2b_ack_timeout: ack1=%b expected 1", ack1_a); end
        req1_a = 1'b0;
        repeat (4) cyc();
        checks++; if (fr_bits[0][k] !== 16'h5A5A)     begin errors++; $display("FAIL b2b_first: got %h expected 5a5a", fr_bits[0][k]); end
        checks++; if (fr_bits[0][k + 1] !== 16'hC3C3) begin errors++; $display("FAIL b2b_second: got %h expected c3c3", fr_bits[0][k + 1]); end
        checks++; if (fr_gap[0][k + 1] !== 3)         begin errors++; $display("FAIL b2b_ss_gap: got %0d expected 3", fr_gap[0][k + 1]); end
        checks++; if (last_blow[0] !== 1)             begin errors++; $display("FAIL b2b_busy_low: got %0d expected 1", last_blow[0]); end
        checks++; if (ack_hi[0][1] !== a1 + 2)        begin errors++; $display("FAIL b2b_acks: got %0d expected %0d", ack_hi[0][1], a1 + 2); end
    endtask

    task automatic test_drop_midframe();
        int k = fr_cnt[0], n = 0;
        req0_a = 1'b1; frame0_a = 16'h0F0F;
        repeat (20) cyc();
        req0_a = 1'b0; frame0_a = 16'h0000;
        while (ack0_a !== 1'b1 && n < 400) begin cyc(); n++; end
        checks++; if (ack0_a !== 1'b1) begin errors++; $display("FAIL drop_ack: ack0=%b expected 1", ack0_a); end
        repeat (4) cyc();
        checks++; if (fr_bits[0][k] !== 16'h0F0F) begin errors++; $display("FAIL drop_bits: got %h expected 0f0f", fr_bits[0][k]); end
        checks++; if (fr_len[0][k] !== 68)        begin errors++; $display("FAIL drop_ss_low: got %0d expected 68", fr_len[0][k]); end
    endtask

    task automatic test_reset_midframe();
        int k = fr_cnt[0], a0 = ack_hi[0][0], nk = noack[0], n = 0;
        req0_a = 1'b1; frame0_a = 16'hA5A5;
        while (!(ss_a === 1'b0 && cur_rises[0] == 6) && n < 400) begin cyc(); n++; end
        repeat (2) cyc();  // now in the sclk-low half of bit 7
        rst_a = 1'b1; req0_a = 1'b0;
        cyc();
        checks++; if (ss_a !== 1'b1 || sclk_a !== 1'b1 || mosi_a !== 1'b1)
                  begin errors++; $display("FAIL midrst_pins: ss=%b sclk=%b mosi=%b expected 1 1 1", ss_a, sclk_a, mosi_a); end
        checks++; if (busy_a !== 1'b0 || ack0_a !== 1'b0)
                  begin errors++; $display("FAIL midrst_busy_ack: busy=%b ack0=%b expected 0 0", busy_a, ack0_a); end
        rst_a = 1'b0;
        cyc();
        run_frame(0, 0, 16'h3C96, "midrst");
        checks++; if (fr_rises[0][k] !== 6)           begin errors++; $display("FAIL midrst_partial: got %0d rises expected 6", fr_rises[0][k]); end
        checks++; if (noack[0] !== nk + 1)            begin errors++; $display("FAIL midrst_noack: got %0d expected %0d", noack[0], nk + 1); end
        checks++; if (fr_bits[0][k + 1] !== 16'h3C96) begin errors++; $display("FAIL midrst_fresh: got %h expected 3c96", fr_bits[0][k + 1]); end
        checks++; if (fr_len[0][k + 1] !== 68)        begin errors++; $display("FAIL midrst_ss_low: got %0d expected 68", fr_len[0][k + 1]); end
        checks++; if (ack_hi[0][0] !== a0 + 1)        begin errors++; $display("FAIL midrst_acks: got %0d expected %0d", ack_hi[0][0], a0 + 1); end
    endtask

    task automatic test_clkdiv1();
        int k = fr_cnt[1], a0 = ack_hi[1][0], v0 = viol[1];
        run_frame(1, 0, 16'h12AA, "div1");
        checks++; if (fr_bits[1][k] !== 16'h12AA) begin errors++; $display("FAIL div1_bits: got %h expected 12aa", fr_bits[1][k]); end
        checks++; if (fr_rises[1][k] !== 16)      begin errors++; $display("FAIL div1_rises: got %0d expected 16", fr_rises[1][k]); end
        checks++; if (fr_len[1][k] !== 34)        begin errors++; $display("FAIL div1_ss_low: got %0d expected 34", fr_len[1][k]); end
        checks++; if (fr_pmin[1][k] !== 2 || fr_pmax[1][k] !== 2)
                  begin errors++; $display("FAIL div1_period: got %0d..%0d expected 2", fr_pmin[1][k], fr_pmax[1][k]); end
        checks++; if (ack_hi[1][0] !== a0 + 1)    begin errors++; $display("FAIL div1_ack0: got %0d expected %0d", ack_hi[1][0], a0 + 1); end
        checks++; if (viol[1] !== v0)             begin errors++; $display("FAIL div1_protocol: violations %0d expected %0d", viol[1], v0); end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        req0_a = 1'b0; req1_a = 1'b0; frame0_a = '0; frame1_a = '0;
        req0_b = 1'b0; req1_b = 1'b0; frame0_b = '0; frame1_b = '0;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_back_to_back();
        test_drop_midframe();
        test_reset_midframe();
        test_clkdiv1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
